// File: rtl/prism_sp_tx_queue_arbiter_pkg.sv
// Shared configuration for the PRISM SP queue arbiters: FSM state encoding
// and the weight helper that turns a zero weight into one frame per turn.
package sp_unit_config;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } arb_state_e;

   // Widest per-queue weight the helper accepts; callers cast down to their width.
   localparam int MAX_WEIGHT_WIDTH = 16;

   function automatic logic [MAX_WEIGHT_WIDTH-1:0] weight_or_one(
      input logic [MAX_WEIGHT_WIDTH-1:0] w
   );
      return (w == '0) ? MAX_WEIGHT_WIDTH'(1) : w;
   endfunction

endpackage

// File: rtl/prism_sp_tx_queue_arbiter_if.sv
// Queue-side bundle between the per-queue TX units (master) and the arbiter (slave).
//
// Handshake: req[i] is a level held while queue i has a complete frame ready.
// grant is one-hot (or zero) and, once asserted, is held unchanged until a
// single-cycle frame_last pulse marks the granted frame's last accepted beat;
// txdone[i] then pulses for one cycle together with grant returning to zero.
interface prism_sp_tx_queue_arbiter_if #(
   parameter int NUM_QUEUES = 2,
   parameter int IDW        = (NUM_QUEUES > 1) ? $clog2(NUM_QUEUES) : 1
);

   logic [NUM_QUEUES-1:0] req;
   logic                  frame_last;
   logic [NUM_QUEUES-1:0] grant;
   logic [IDW-1:0]        grant_id;
   logic [NUM_QUEUES-1:0] txdone;

   modport master (
      output req, frame_last,
      input  grant, grant_id, txdone
   );

   modport slave (
      input  req, frame_last,
      output grant, grant_id, txdone
   );

endinterface

// File: rtl/prism_sp_tx_queue_arbiter_rr_pick.sv
// Combinational round-robin search: first eligible queue at or after ptr_i,
// wrapping around; shared by the TX and RX queue arbiters.
module prism_sp_rr_pick #(
   parameter int N   = 2,
   parameter int IDW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]   eligible_i,
   input  logic [IDW-1:0] ptr_i,
   output logic           valid_o,
   output logic [IDW-1:0] idx_o
);

   // Scan offsets from the far end down so the smallest offset is the last write.
   always_comb begin
      valid_o = 1'b0;
      idx_o   = '0;
      for (int k = N - 1; k >= 0; k--) begin
         if (eligible_i[(int'(ptr_i) + k) % N]) begin
            valid_o = 1'b1;
            idx_o   = IDW'((int'(ptr_i) + k) % N);
         end
      end
   end

endmodule

// File: rtl/prism_sp_tx_queue_arbiter.sv
// Weighted round-robin owner of the GEM TX datapath: grants one queue per
// frame, lets the owner keep its turn for `weight` frames, then moves on.
module prism_sp_tx_queue_arbiter
   import sp_unit_config::*;
#(
   parameter int NUM_QUEUES   = 2,
   parameter int WEIGHT_WIDTH = 4
) (
   input  logic                               clk,
   input  logic                               resetn,
   input  logic [NUM_QUEUES-1:0]              queue_enable,
   input  logic [NUM_QUEUES*WEIGHT_WIDTH-1:0] queue_weight,
   prism_sp_tx_queue_arbiter_if.slave         tx_if,
   output logic                               protocol_error,
   output arb_state_e                         dbg_state
);

   localparam int IDW = (NUM_QUEUES > 1) ? $clog2(NUM_QUEUES) : 1;

   arb_state_e              state_q, state_d;
   logic [NUM_QUEUES-1:0]   grant_q, grant_d;
   logic [IDW-1:0]          grant_id_q, grant_id_d;
   logic [NUM_QUEUES-1:0]   txdone_q, txdone_d;
   logic                    perr_q, perr_d;
   logic [IDW-1:0]          rr_ptr_q, rr_ptr_d;
   logic [WEIGHT_WIDTH-1:0] credit_q, credit_d;

   logic                    pick_valid;
   logic [IDW-1:0]          pick_idx;
   logic [WEIGHT_WIDTH-1:0] win_weight;
   logic [WEIGHT_WIDTH-1:0] credit_dec;
   logic [IDW-1:0]          next_ptr;

   prism_sp_rr_pick #(
      .N   (NUM_QUEUES),
      .IDW (IDW)
   ) u_rr_pick (
      .eligible_i (tx_if.req & queue_enable),
      .ptr_i      (rr_ptr_q),
      .valid_o    (pick_valid),
      .idx_o      (pick_idx)
   );

   assign win_weight = queue_weight[int'(pick_idx)*WEIGHT_WIDTH +: WEIGHT_WIDTH];
   assign credit_dec = credit_q - WEIGHT_WIDTH'(1);
   assign next_ptr   = (grant_id_q == IDW'(NUM_QUEUES - 1)) ? '0 : grant_id_q + IDW'(1);

   // grant_id_q keeps naming the last owner while idle, so the credit check
   // below can tell whether the owner is continuing its turn.
   always_comb begin
      state_d    = state_q;
      grant_d    = grant_q;
      grant_id_d = grant_id_q;
      txdone_d   = '0;
      perr_d     = perr_q;
      rr_ptr_d   = rr_ptr_q;
      credit_d   = credit_q;
      case (state_q)
         ST_IDLE: begin
            if (tx_if.frame_last) perr_d = 1'b1;
            if (pick_valid) begin
               state_d           = ST_BUSY;
               grant_d           = '0;
               grant_d[pick_idx] = 1'b1;
               grant_id_d        = pick_idx;
               rr_ptr_d          = pick_idx;
               if (pick_idx != grant_id_q || credit_q == '0)
                  credit_d = WEIGHT_WIDTH'(weight_or_one(MAX_WEIGHT_WIDTH'(win_weight)));
            end
         end
         ST_BUSY: begin
            if (tx_if.frame_last) begin
               state_d  = ST_IDLE;
               grant_d  = '0;
               txdone_d = grant_q;
               credit_d = credit_dec;
               rr_ptr_d = (credit_dec == '0) ? next_ptr : grant_id_q;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q    <= ST_IDLE;
         grant_q    <= '0;
         grant_id_q <= '0;
         txdone_q   <= '0;
         perr_q     <= 1'b0;
         rr_ptr_q   <= '0;
         credit_q   <= '0;
      end else begin
         state_q    <= state_d;
         grant_q    <= grant_d;
         grant_id_q <= grant_id_d;
         txdone_q   <= txdone_d;
         perr_q     <= perr_d;
         rr_ptr_q   <= rr_ptr_d;
         credit_q   <= credit_d;
      end
   end

   assign tx_if.grant    = grant_q;
   assign tx_if.grant_id = grant_id_q;
   assign tx_if.txdone   = txdone_q;
   assign protocol_error = perr_q;
   assign dbg_state      = state_q;

endmodule

// File: tb/tb_prism_sp_tx_queue_arbiter.sv
// Directed bench for the TX queue arbiter: weighted rotation, zero weight,
// enable drop mid-frame, idle frame_last, mid-frame reset, owner continuation.
module tb_prism_sp_tx_queue_arbiter;
   import sp_unit_config::*;

   localparam int NQ = 2;
   localparam int WW = 4;

   logic            clk = 1'b0;
   logic            resetn = 1'b0;
   logic [NQ-1:0]   queue_enable;
   logic [NQ*WW-1:0] queue_weight;
   logic            protocol_error;
   arb_state_e      dbg_state;

   int n_chk  = 0;
   int n_pass = 0;
   int n_fail = 0;

   prism_sp_tx_queue_arbiter_if #(.NUM_QUEUES(NQ)) tx_if ();

   prism_sp_tx_queue_arbiter #(
      .NUM_QUEUES   (NQ),
      .WEIGHT_WIDTH (WW)
   ) dut (
      .clk            (clk),
      .resetn         (resetn),
      .queue_enable   (queue_enable),
      .queue_weight   (queue_weight),
      .tx_if          (tx_if),
      .protocol_error (protocol_error),
      .dbg_state      (dbg_state)
   );

   always #5 clk = ~clk;

   function automatic logic [NQ-1:0] oh(input int i);
      logic [NQ-1:0] v;
      v    = '0;
      v[i] = 1'b1;
      return v;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_chk++;
      assert (obs === exp_v) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic pulse_last();
      tx_if.frame_last = 1'b1;
      step(1);
      tx_if.frame_last = 1'b0;
   endtask

   task automatic do_reset();
      resetn           = 1'b0;
      tx_if.req        = '0;
      tx_if.frame_last = 1'b0;
      queue_enable     = '0;
      queue_weight     = '0;
      step(2);
      chk("rst_grant",    32'(tx_if.grant),    32'(0));
      chk("rst_grant_id", 32'(tx_if.grant_id), 32'(0));
      chk("rst_txdone",   32'(tx_if.txdone),   32'(0));
      chk("rst_perr",     32'(protocol_error),  32'(0));
      chk("rst_state",    32'(dbg_state),       32'(ST_IDLE));
      resetn = 1'b1;
   endtask

   int seq_a [6] = '{0, 0, 1, 0, 0, 1};

   initial begin
      tx_if.req        = '0;
      tx_if.frame_last = 1'b0;
      queue_enable     = '0;
      queue_weight     = '0;

      // Weights 2/1, both requesting, frame_last every 10 cycles.
      do_reset();
      queue_enable = 2'b11;
      queue_weight = {4'd1, 4'd2};
      tx_if.req    = 2'b11;
      step(1);
      for (int f = 0; f < 6; f++) begin
         chk("a_grant",    32'(tx_if.grant),    32'(oh(seq_a[f])));
         chk("a_grant_id", 32'(tx_if.grant_id), 32'(seq_a[f]));
         step(8);
         chk("a_hold",     32'(tx_if.grant),    32'(oh(seq_a[f])));
         pulse_last();
         chk("a_gap",      32'(tx_if.grant),    32'(0));
         chk("a_txdone",   32'(tx_if.txdone),   32'(oh(seq_a[f])));
         step(1);
         chk("a_txdone_1", 32'(tx_if.txdone),   32'(0));
      end

      // Only queue 0 requesting, weight 0 behaves as 1.
      do_reset();
      queue_enable = 2'b11;
      queue_weight = {4'd0, 4'd0};
      tx_if.req    = 2'b01;
      step(1);
      for (int f = 0; f < 3; f++) begin
         chk("b_grant",  32'(tx_if.grant),  32'(oh(0)));
         step(3);
         pulse_last();
         chk("b_gap",    32'(tx_if.grant),  32'(0));
         chk("b_txdone", 32'(tx_if.txdone), 32'(oh(0)));
         step(1);
         chk("b_regrant", 32'(tx_if.grant), 32'(oh(0)));
         chk("b_txdone_1", 32'(tx_if.txdone), 32'(0));
      end

      // queue_enable[1] dropped while queue 1 owns the datapath.
      do_reset();
      queue_enable = 2'b11;
      queue_weight = {4'd1, 4'd1};
      tx_if.req    = 2'b11;
      step(1);
      chk("c_first", 32'(tx_if.grant), 32'(oh(0)));
      step(3);
      pulse_last();
      step(1);
      chk("c_q1", 32'(tx_if.grant), 32'(oh(1)));
      step(2);
      queue_enable = 2'b01;
      step(3);
      chk("c_hold",    32'(tx_if.grant),    32'(oh(1)));
      chk("c_hold_id", 32'(tx_if.grant_id), 32'(1));
      pulse_last();
      chk("c_txdone", 32'(tx_if.txdone), 32'(oh(1)));
      chk("c_gap",    32'(tx_if.grant),  32'(0));
      step(1);
      chk("c_next_q0", 32'(tx_if.grant), 32'(oh(0)));
      step(3);
      pulse_last();
      step(1);
      chk("c_no_q1", 32'(tx_if.grant), 32'(oh(0)));

      // frame_last while idle.
      do_reset();
      chk("d_perr_0", 32'(protocol_error), 32'(0));
      pulse_last();
      chk("d_perr_1",  32'(protocol_error), 32'(1));
      chk("d_txdone",  32'(tx_if.txdone),   32'(0));
      chk("d_grant",   32'(tx_if.grant),    32'(0));
      chk("d_state",   32'(dbg_state),      32'(ST_IDLE));
      step(3);
      chk("d_perr_sticky", 32'(protocol_error), 32'(1));
      queue_enable = 2'b11;
      queue_weight = {4'd1, 4'd1};
      tx_if.req    = 2'b10;
      step(1);
      chk("d_grant_q1", 32'(tx_if.grant),    32'(oh(1)));
      chk("d_grant_id", 32'(tx_if.grant_id), 32'(1));
      step(2);
      pulse_last();
      chk("d_txdone_q1", 32'(tx_if.txdone),   32'(oh(1)));
      chk("d_perr_kept", 32'(protocol_error), 32'(1));

      // Reset asserted for one cycle during a queue-1 frame.
      do_reset();
      queue_enable = 2'b11;
      queue_weight = {4'd1, 4'd1};
      tx_if.req    = 2'b11;
      step(3);
      pulse_last();
      step(1);
      chk("e_q1", 32'(tx_if.grant), 32'(oh(1)));
      step(2);
      resetn = 1'b0;
      #1;
      chk("e_async_grant",  32'(tx_if.grant),  32'(0));
      chk("e_async_txdone", 32'(tx_if.txdone), 32'(0));
      chk("e_async_state",  32'(dbg_state),    32'(ST_IDLE));
      @(posedge clk);
      #1;
      resetn = 1'b1;
      chk("e_rel_txdone", 32'(tx_if.txdone), 32'(0));
      step(1);
      chk("e_first_q0",   32'(tx_if.grant),    32'(oh(0)));
      chk("e_first_id",   32'(tx_if.grant_id), 32'(0));
      chk("e_txdone_0",   32'(tx_if.txdone),   32'(0));

      // Weights 1/1, req[1] withdrawn while queue 0 holds the turn.
      do_reset();
      queue_enable = 2'b11;
      queue_weight = {4'd1, 4'd1};
      tx_if.req    = 2'b11;
      step(1);
      chk("f_first", 32'(tx_if.grant), 32'(oh(0)));
      step(1);
      tx_if.req = 2'b01;
      step(2);
      for (int f = 0; f < 3; f++) begin
         pulse_last();
         chk("f_gap",    32'(tx_if.grant),  32'(0));
         chk("f_txdone", 32'(tx_if.txdone), 32'(oh(0)));
         step(1);
         chk("f_regrant", 32'(tx_if.grant), 32'(oh(0)));
         step(2);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/prism_sp_tx_queue_arbiter.md
PRISM_SP_TX_QUEUE_ARBITER -- requirements
Module: prism_sp_tx_queue_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_QUEUES, default 2, giving the number of TX queues sharing the GEM TX datapath.
REQ-002 The block SHALL have parameter WEIGHT_WIDTH, default 4, giving the width of each per-queue weight (frames per turn).
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset: clock in 1, rising-edge system clock; resetn in 1, asynchronous active-low reset.
REQ-004 queue_enable  in  NUM_QUEUES  per-queue enable, from configuration registers.
REQ-005 queue_weight  in  NUM_QUEUES*WEIGHT_WIDTH  frames per turn per queue; queue i occupies bits [i*WEIGHT_WIDTH +: WEIGHT_WIDTH].
REQ-006 req  in  NUM_QUEUES  level signal; queue i has a complete frame ready to send.
REQ-007 frame_last  in  1  single-cycle pulse: last beat of the granted frame was accepted by gem_tx (tvalid&tready&tlast).
REQ-008 grant  out  NUM_QUEUES  one-hot (or zero) ownership of the GEM TX datapath.
REQ-009 grant_id  out  $clog2(NUM_QUEUES)  index of the granted queue; valid while grant != 0.
REQ-010 txdone  out  NUM_QUEUES  single-cycle completion pulse per queue, ORed externally into gem_irq_tx.
REQ-011 protocol_error  out  1  sticky flag: frame_last was seen with no grant asserted.

Function
REQ-012 The FSM SHALL have exactly two states: IDLE (grant=0) and BUSY (grant held).
REQ-013 In IDLE, if any queue i has req[i]&queue_enable[i], the block SHALL select a winner and enter BUSY, with grant/grant_id registered and visible on the next cycle (1-cycle req->grant latency).
REQ-014 Winner selection SHALL be round-robin starting at pointer rr_ptr; queue rr_ptr wins if eligible, otherwise the first eligible queue found by ascending search with wrap-around.
REQ-015 When the winner differs from the previous owner, or the owner's credit is 0, credit SHALL be loaded with the winner's weight, and a weight of 0 SHALL be treated as 1.
REQ-016 In BUSY, grant SHALL remain constant until frame_last; req and queue_enable changes SHALL NOT revoke a grant mid-frame.
REQ-017 On frame_last in BUSY: the FSM SHALL go to IDLE, grant SHALL be 0 on the next cycle, txdone[grant_id] SHALL pulse for exactly that next cycle, and credit SHALL decrement by 1.
REQ-018 After the decrement, if credit==0, rr_ptr SHALL advance to grant_id+1 (mod NUM_QUEUES); otherwise rr_ptr SHALL stay on the owner, which wins again if still eligible.
REQ-019 If the owner is not eligible in IDLE, its remaining credit SHALL be discarded and rr_ptr SHALL move with the search.
REQ-020 A new grant SHALL appear no earlier than 2 cycles after frame_last, giving one guaranteed idle cycle between frames.
REQ-021 frame_last in IDLE SHALL be ignored for FSM/txdone purposes and SHALL set protocol_error, which clears only on reset.
REQ-022 Credit SHALL be WEIGHT_WIDTH bits wide; a decrement from 0 SHALL NOT occur, because credit is always >=1 while BUSY.

Reset
REQ-023 On resetn low, the block SHALL asynchronously reach: state=IDLE, grant=0, grant_id=0, txdone=0, protocol_error=0, rr_ptr=0, credit=0.
REQ-024 Reset asserted mid-frame SHALL drop the grant immediately; no txdone SHALL be generated for the aborted frame.

Structure
REQ-025 The FSM state enum and the helper function for weight-0-to-1 SHALL reside in sp_unit_config.
REQ-026 The round-robin search SHALL be one combinational sub-module, prism_sp_rr_pick (inputs: eligible vector and pointer; outputs: valid and index), reusable for RX queues.
REQ-027 The block SHALL be instantiated between the per-queue TX units and gem_tx, with txdone replacing queue_0_txdone/queue_1_txdone.

Verification
REQ-028 The bench SHALL cover weights 2/1, both req held high, frame_last every 10 cycles: grant sequence 0,0,1,0,0,1, each txdone pulse one cycle after its frame_last.
REQ-029 The bench SHALL cover req[0] only, weight 0: queue 0 is re-granted every frame; grant is 0 for exactly one cycle after each frame_last.
REQ-030 The bench SHALL cover queue_enable[1] dropped mid-frame of queue 1: the grant holds until frame_last, txdone[1] pulses, and no further grant goes to queue 1.
REQ-031 The bench SHALL cover frame_last pulsed in IDLE: protocol_error=1 and stays 1, txdone stays 0, and the next arbitration is unaffected.
REQ-032 The bench SHALL cover resetn low for 1 cycle during a queue-1 frame: grant=0 asynchronously, no txdone, and after release with both req high, the first grant goes to queue 0.
REQ-033 The bench SHALL cover weights 1/1 with req[1] deasserted while queue 0 has credit: queue 0 is granted repeatedly with no idle beyond 1 cycle.
